clock_set_ctrl: RTL



---
 rtl/clock_pkg.sv | 31 +++
 rtl/clock_set_ctrl_if.sv | 28 ++
 rtl/button_conditioner.sv | 84 ++++++++
 rtl/clock_set_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, limits and wrap helpers for the binary clock time-setting path.
package clock_pkg;

    localparam int unsigned HOURS_LIMIT   = 24;
    localparam int unsigned MINUTES_LIMIT = 60;
    localparam int unsigned HOURS_W       = 5;
    localparam int unsigned MINUTES_W     = 6;
    localparam int unsigned MODE_W        = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2
    } mode_e;

    // Shadow time being edited
    typedef struct packed {
        logic [HOURS_W-1:0]   hours;
        logic [MINUTES_W-1:0] minutes;
    } hm_t;

    // >= compare so an out-of-range captured value falls back to 0
    function automatic logic [HOURS_W-1:0] inc_hours(input logic [HOURS_W-1:0] h);
        return (h >= HOURS_W'(HOURS_LIMIT - 1)) ? '0 : h + HOURS_W'(1);
    endfunction

    function automatic logic [MINUTES_W-1:0] inc_minutes(input logic [MINUTES_W-1:0] m);
        return (m >= MINUTES_W'(MINUTES_LIMIT - 1)) ? '0 : m + MINUTES_W'(1);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button inputs, live time inputs and counter-control outputs of the set controller.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic                 btn_mode;
    logic                 btn_inc;
    logic [HOURS_W-1:0]   cur_hours;
    logic [MINUTES_W-1:0] cur_minutes;
    logic [MODE_W-1:0]    mode;
    logic                 run_en;
    logic                 load;
    logic [HOURS_W-1:0]   load_hours;
    logic [MINUTES_W-1:0] load_minutes;
    logic                 blink_on;

    // Driver side: buttons and live time
    modport master (
        output btn_mode, btn_inc, cur_hours, cur_minutes,
        input  mode, run_en, load, load_hours, load_minutes, blink_on
    );

    // Controller side
    modport slave (
        input  btn_mode, btn_inc, cur_hours, cur_minutes,
        output mode, run_en, load, load_hours, load_minutes, blink_on
    );

endinterface

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect one raw button; optional hold-to-repeat.
module button_conditioner #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 16,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse_c
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [DEB_W-1:0] deb_cnt;
    logic             commit_c;
    logic             press_c;
    logic             rep_fire_c;

    // Level flips on the last of DEB_CYCLES consecutive differing samples
    assign commit_c = (sync2 != level) && (deb_cnt == DEB_W'(DEB_CYCLES - 1));
    assign press_c  = commit_c && sync2;
    assign pulse_c  = press_c || rep_fire_c;

    // Synchroniser and debounce counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                deb_cnt <= '0;
            end else if (commit_c) begin
                level   <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    if (REPEAT_EN) begin : g_rep
        localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

        logic [REP_W-1:0] rep_cnt;
        logic             rep_first;

        // Gated by the synchronised level so a release stops repeats before debounce completes
        assign rep_fire_c = level && sync2 &&
                            (rep_first ? (rep_cnt >= REP_W'(REPEAT_DELAY))
                                       : (rep_cnt >= REP_W'(REPEAT_PERIOD)));

        // Cycles since the last emitted pulse while held
        always_ff @(posedge clk) begin
            if (rst) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else if (press_c) begin
                rep_cnt   <= REP_W'(1);
                rep_first <= 1'b1;
            end else if (!level) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else if (rep_fire_c) begin
                rep_cnt   <= REP_W'(1);
                rep_first <= 1'b0;
            end else if (rep_cnt < REP_W'(REP_MAX)) begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end else begin : g_no_rep
        assign rep_fire_c = 1'b0;
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode machine, shadow time, idle timeout and blink gate for setting the binary clock.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_DELAY  = 16,
    parameter int unsigned REPEAT_PERIOD = 4,
    parameter int unsigned BLINK_HALF    = 8,
    parameter int unsigned TIMEOUT       = 256
) (
    input  logic             clk,
    input  logic             rst,
    clock_set_ctrl_if.slave  bus
);

    localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

    mode_e              state,     state_n;
    hm_t                shadow,    shadow_n;
    logic               run_en,    run_en_n;
    logic               load,      load_n;
    logic               blink_on,  blink_n;
    logic [IDLE_W-1:0]  idle_cnt,  idle_n;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
    logic               mode_pulse_c;
    logic               inc_pulse_c;

    button_conditioner #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_EN     (1'b0),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_mode_btn (
        .clk     (clk),
        .rst     (rst),
        .raw     (bus.btn_mode),
        .pulse_c (mode_pulse_c)
    );

    button_conditioner #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_EN     (1'b1),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_inc_btn (
        .clk     (clk),
        .rst     (rst),
        .raw     (bus.btn_inc),
        .pulse_c (inc_pulse_c)
    );

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MODE_RUN;
            shadow    <= '0;
            run_en    <= 1'b1;
            load      <= 1'b0;
            blink_on  <= 1'b1;
            idle_cnt  <= '0;
            blink_cnt <= '0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            run_en    <= run_en_n;
            load      <= load_n;
            blink_on  <= blink_n;
            idle_cnt  <= idle_n;
            blink_cnt <= blink_cnt_n;
        end
    end

    // Next state: mode press beats inc, then timeout, otherwise count idle and blink
    always_comb begin
        state_n     = state;
        shadow_n    = shadow;
        run_en_n    = run_en;
        load_n      = 1'b0;
        blink_n     = blink_on;
        idle_n      = idle_cnt;
        blink_cnt_n = blink_cnt;

        case (state)
            MODE_RUN: begin
                run_en_n    = 1'b1;
                idle_n      = '0;
                blink_n     = 1'b1;
                blink_cnt_n = '0;
                if (mode_pulse_c) begin
                    state_n          = MODE_SET_H;
                    shadow_n.hours   = bus.cur_hours;
                    shadow_n.minutes = bus.cur_minutes;
                    run_en_n         = 1'b0;
                end
            end

            MODE_SET_H, MODE_SET_M: begin
                if (mode_pulse_c) begin
                    idle_n      = '0;
                    blink_n     = 1'b1;
                    blink_cnt_n = '0;
                    if (state == MODE_SET_H) begin
                        state_n = MODE_SET_M;
                    end else begin
                        state_n  = MODE_RUN;
                        load_n   = 1'b1;
                        run_en_n = 1'b1;
                    end
                end else if (inc_pulse_c) begin
                    idle_n      = '0;
                    blink_n     = 1'b1;
                    blink_cnt_n = '0;
                    if (state == MODE_SET_H) begin
                        shadow_n.hours = inc_hours(shadow.hours);
                    end else begin
                        shadow_n.minutes = inc_minutes(shadow.minutes);
                    end
                end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    state_n     = MODE_RUN;
                    run_en_n    = 1'b1;
                    idle_n      = '0;
                    blink_n     = 1'b1;
                    blink_cnt_n = '0;
                end else begin
                    idle_n = idle_cnt + IDLE_W'(1);
                    if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
                        blink_cnt_n = '0;
                        blink_n     = !blink_on;
                    end else begin
                        blink_cnt_n = blink_cnt + BLINK_W'(1);
                    end
                end
            end

            default: begin
                state_n     = MODE_RUN;
                run_en_n    = 1'b1;
                idle_n      = '0;
                blink_n     = 1'b1;
                blink_cnt_n = '0;
            end
        endcase
    end

    assign bus.mode         = state;
    assign bus.run_en       = run_en;
    assign bus.load         = load;
    assign bus.load_hours   = shadow.hours;
    assign bus.load_minutes = shadow.minutes;
    assign bus.blink_on     = blink_on;

endmodule
